// File: rtl/edge_det_pkg.sv
// Shared mode encoding for the edge detector bank.
// Build option: EDGE_DET_FILTER_EN enables the per-channel glitch filter.
package edge_det_pkg;

   typedef logic [1:0] edge_mode_t;

   localparam edge_mode_t MODE_OFF  = 2'b00;
   localparam edge_mode_t MODE_RISE = 2'b01;
   localparam edge_mode_t MODE_FALL = 2'b10;
   localparam edge_mode_t MODE_BOTH = 2'b11;

endpackage

// File: rtl/edge_det_chan.sv
// One channel: synchroniser, optional glitch filter, level, edge compare.
// Build option: EDGE_DET_FILTER_EN enables the glitch filter.
module edge_det_chan
   import edge_det_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in,
   input  edge_mode_t mode,
   input  logic       clear,
   input  logic       warm,
   output logic       level,
   output logic       pulse,
   output logic       pending
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   logic                   accept;
   logic                   hit;
   logic                   pulse_d;

   assign s = sync[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (!reset) sync <= '0;
      else        sync <= {sync[SYNC_STAGES-2:0], in};
   end

`ifdef EDGE_DET_FILTER_EN
   localparam int CW = $clog2(FILTER_CYCLES) + 1;

   logic [CW-1:0] cnt;

   assign accept = (s != level) && (cnt == CW'(FILTER_CYCLES - 1));

   // counter only runs while the synchronised input disagrees with level
   always_ff @(posedge clk) begin
      if (!reset || warm || s == level || accept) cnt <= '0;
      else                                        cnt <= cnt + 1'b1;
   end
`else
   assign accept = (s != level);
`endif

   always_ff @(posedge clk) begin
      if (!reset)      level <= 1'b0;
      else if (warm)   level <= s;
      else if (accept) level <= s;
   end

   always_comb begin
      hit = 1'b0;
      unique case (mode)
         MODE_OFF:  hit = 1'b0;
         MODE_RISE: hit = s;
         MODE_FALL: hit = ~s;
         MODE_BOTH: hit = 1'b1;
      endcase
   end

   assign pulse_d = !warm && accept && hit;

   // a new edge outranks a clear on the same cycle
   always_ff @(posedge clk) begin
      if (!reset) begin
         pulse   <= 1'b0;
         pending <= 1'b0;
      end else begin
         pulse   <= pulse_d;
         pending <= pulse_d | (pending & ~clear);
      end
   end

endmodule

// File: rtl/edge_detector_bank.sv
// Multi-channel edge detector with shared warm-up and irq OR.
// Build option: EDGE_DET_FILTER_EN enables the per-channel glitch filter.
module edge_detector_bank
   import edge_det_pkg::*;
#(
   parameter int CHANNELS      = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [CHANNELS-1:0]   in,
   input  logic [2*CHANNELS-1:0] mode,
   input  logic [CHANNELS-1:0]   clear,
   output logic [CHANNELS-1:0]   level,
   output logic [CHANNELS-1:0]   pulse,
   output logic [CHANNELS-1:0]   pending,
   output logic                  irq
);

   localparam int WARM = SYNC_STAGES + 1;
   localparam int WW   = $clog2(WARM + 1);

   logic [WW-1:0] wcnt;
   logic          warm;

   // level tracks the input unchecked until the sync chain holds real data
   assign warm = (wcnt != WW'(WARM));

   always_ff @(posedge clk) begin
      if (!reset)    wcnt <= '0;
      else if (warm) wcnt <= wcnt + 1'b1;
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      edge_det_chan #(
         .SYNC_STAGES   (SYNC_STAGES),
         .FILTER_CYCLES (FILTER_CYCLES)
      ) u_chan (
         .clk     (clk),
         .reset   (reset),
         .in      (in[i]),
         .mode    (edge_mode_t'(mode[2*i+1:2*i])),
         .clear   (clear[i]),
         .warm    (warm),
         .level   (level[i]),
         .pulse   (pulse[i]),
         .pending (pending[i])
      );
   end

   assign irq = |pending;

endmodule

// File: doc/edge_detector_bank.md
# edge_detector_bank

Multi-channel, parametrised edge detector for asynchronous UART-side control inputs (RX line, CTS, DSR, external strobes). Each channel synchronises its input, optionally glitch-filters it, detects rising, falling or both edges per a run-time mode, and emits a one-cycle pulse plus a sticky pending flag. It sits between the pad-level inputs and the UART control/interrupt logic, replacing single-bit, single-mode edge detection.

## Interface
- CHANNELS, 4, number of independent input channels (>=1)
- SYNC_STAGES, 2, synchroniser flip-flops per channel (>=2)
- FILTER_CYCLES, 4, consecutive stable cycles required before a level change is accepted (>=1; used only with filter compiled in)

- clk  input  1  system clock
- reset  input  1  synchronous, active-low reset
- in  input  CHANNELS  raw asynchronous inputs
- mode  input  2*CHANNELS  per-channel mode, bits [2i+1:2i]: 00 off, 01 rising, 10 falling, 11 both
- clear  input  CHANNELS  per-channel pending clear, sampled each edge
- level  output  CHANNELS  synchronised (filtered) level per channel
- pulse  output  CHANNELS  one-cycle registered edge pulse per channel
- pending  output  CHANNELS  sticky edge flag per channel
- irq  output  1  OR of all pending bits

## Operation
- Per channel: SYNC_STAGES-deep shift register -> filter -> level register -> edge compare against mode.
- Edge event: level register changes value; rising = 0->1, falling = 1->0; pulse[i] asserted if event matches mode[i]; mode 00 never pulses but level still tracks.
- Filter (when compiled in): per-channel counter, width clog2(FILTER_CYCLES)+1; increments each cycle sync output != level; resets to 0 whenever equal; when counter == FILTER_CYCLES-1 and still different, level takes sync value, counter -> 0, edge event.
- Warm-up: after reset deassert, shared counter holds bank in warm-up for SYNC_STAGES+1 clock edges; during warm-up level follows sync output directly, filter counters held at 0, no pulses, no pending set. Prevents a spurious edge when an input is already high at reset release.
- pending[i]: set by pulse[i]; cleared by clear[i]; simultaneous pulse and clear -> pending remains 1 (set wins).
- Mode change: applies to the next edge event only; no retroactive pulse.
- irq: combinational OR of pending registers.

## Timing
- Reset (reset == 0 at a clk edge): sync regs, level, filter counters, pulse, pending -> 0; irq -> 0; warm-up counter restarts. Reset mid-filter discards partial count; mid-pulse, pulse drops at that edge.
- Latency: input change first sampled at edge k -> level and pulse update at edge k+SYNC_STAGES+F-1, F = FILTER_CYCLES (filter in) or 1 (filter out).
- pulse width exactly one cycle per event; back-to-back events on consecutive accepted level changes give separate pulses.
- Glitch shorter than FILTER_CYCLES cycles (post-sync) -> no level change, no pulse.
- pending visible one edge after the pulse-setting edge? No: pending and pulse set at the same edge.
- clear takes effect at the edge it is sampled; pending low the following cycle.

## Configuration
- EDGE_DET_FILTER_EN defined: glitch filter and counters instantiated, FILTER_CYCLES honoured.
- Not defined: no filter logic; level registers sync output every cycle; FILTER_CYCLES ignored; latency SYNC_STAGES edges.

## Structure
- Package edge_det_pkg: mode encoding localparams (MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH) and edge_mode_t 2-bit typedef.
- Sub-module edge_det_chan: one channel (sync chain, filter, level, edge compare, pending); top generates CHANNELS instances, owns warm-up counter and irq OR.

## Test plan
- Defaults, filter in, ch0 mode 01, in[0] 0->1 held at edge 20 -> level[0] and pulse[0] high after edge 25, pulse one cycle, pending[0] = 1, irq = 1.
- ch1 mode 11, 2-cycle high glitch then steady 0 -> no pulse, pending[1] stays 0; then 10-cycle high -> two pulses (rise, fall).
- in all high through reset release -> no pulse/pending during or after warm-up, level = 4'hF after warm-up.
- pulse[2] and clear[2] same edge -> pending[2] = 1; clear alone next cycle -> pending[2] = 0, irq = 0.
- mode 00 on ch3, toggle in[3] -> level[3] follows, pulse[3]/pending[3] stay 0; switch to 10 -> next falling edge pulses.
- reset asserted midway through filter count -> all outputs 0 next cycle; after release, edge detected only after full warm-up and FILTER_CYCLES.
